// File: rtl/seg_display_reader_if.sv
// seg_display_reader_if: digit strobe in, decoded time word and status pulses out
interface seg_display_reader_if;
   logic [6:0]  seg_code;
   logic [1:0]  digit_sel;
   logic        am_pm_in;
   logic        seg_valid;
   logic        seg_ready;
   logic [10:0] bin_time;
   logic        time_valid;
   logic        frame_err;
   modport master (
      output seg_code, digit_sel, am_pm_in, seg_valid,
      input  seg_ready, bin_time, time_valid, frame_err
   );
   modport slave (
      input  seg_code, digit_sel, am_pm_in, seg_valid,
      output seg_ready, bin_time, time_valid, frame_err
   );
endinterface

// File: rtl/seg_display_reader.sv
// seg_display_reader: collects four 7-segment digits and rebuilds the packed time word
module seg_display_reader (
   input logic                  clk,
   input logic                  rst_n,
   seg_display_reader_if.slave  bus
);
   typedef enum logic [2:0] {W0, W1, W2, W3, CONV} state_t;
   state_t            state_q, state_d;
   logic              bad_q, bad_d;
   logic              am_pm_q, am_pm_d;
   logic              time_valid_q, time_valid_d;
   logic              frame_err_q, frame_err_d;
   logic [3:0][3:0]   dig_q, dig_d;
   logic [10:0]       bin_time_q, bin_time_d;
   logic [3:0]        val;
   logic              legal, dig_bad, accept;
   logic [3:0]        hours;
   logic [5:0]        minutes;
   always_comb begin
      val   = 4'd0;
      legal = 1'b1;
      case (bus.seg_code)
         7'b1111110: val = 4'd0;
         7'b0110000: val = 4'd1;
         7'b1101101: val = 4'd2;
         7'b1111001: val = 4'd3;
         7'b0110011: val = 4'd4;
         7'b1011011: val = 4'd5;
         7'b1011111: val = 4'd6;
         7'b1110000: val = 4'd7;
         7'b1111111: val = 4'd8;
         7'b1111011: val = 4'd9;
         7'b0000000: legal = bus.digit_sel == 2'd0;
         default:    legal = 1'b0;
      endcase
   end
   // a digit is only ever stored at the position named by digit_sel, so range checks key off it
   assign dig_bad = !legal
                  | (bus.digit_sel == 2'd0 && val > 4'd1)
                  | (bus.digit_sel == 2'd1 && dig_q[0] == 4'd1 && val > 4'd5)
                  | (bus.digit_sel == 2'd2 && val > 4'd5);
   assign accept  = bus.seg_valid && state_q != CONV;
   assign hours   = dig_q[0][0] ? 4'd10 + dig_q[1] : dig_q[1];
   assign minutes = 6'(dig_q[2]) * 6'd10 + 6'(dig_q[3]);
   always_comb begin
      state_d      = state_q;
      bad_d        = bad_q;
      dig_d        = dig_q;
      am_pm_d      = am_pm_q;
      bin_time_d   = bin_time_q;
      time_valid_d = 1'b0;
      frame_err_d  = 1'b0;
      if (state_q == CONV) begin
         time_valid_d = !bad_q;
         frame_err_d  = bad_q;
         bin_time_d   = bad_q ? bin_time_q : {~am_pm_q, hours, minutes};
         state_d      = W0;
      end else if (accept) begin
         if (bus.digit_sel == 2'(state_q)) begin
            dig_d[bus.digit_sel] = val;
            bad_d   = (state_q == W0 ? 1'b0 : bad_q) | dig_bad;
            am_pm_d = state_q == W3 ? bus.am_pm_in : am_pm_q;
            state_d = state_t'(state_q + 3'd1);
         end else if (state_q != W0) begin
            frame_err_d = 1'b1;
            bad_d       = bus.digit_sel == 2'd0 && dig_bad;
            dig_d[0]    = bus.digit_sel == 2'd0 ? val : dig_q[0];
            state_d     = bus.digit_sel == 2'd0 ? W1 : W0;
         end
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= W0;
         bad_q        <= 1'b0;
         dig_q        <= '0;
         am_pm_q      <= 1'b0;
         bin_time_q   <= '0;
         time_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         bad_q        <= bad_d;
         dig_q        <= dig_d;
         am_pm_q      <= am_pm_d;
         bin_time_q   <= bin_time_d;
         time_valid_q <= time_valid_d;
         frame_err_q  <= frame_err_d;
      end
   end
   assign bus.seg_ready  = state_q != CONV;
   assign bus.bin_time   = bin_time_q;
   assign bus.time_valid = time_valid_q;
   assign bus.frame_err  = frame_err_q;
endmodule

// File: tb/tb_seg_display_reader.sv
// tb_seg_display_reader: frame table, ordering/reset sequences and random traffic against a frame-level model
module tb_seg_display_reader;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;
   seg_display_reader_if bus ();
   seg_display_reader dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   typedef struct packed {
      logic [3:0][6:0] c;
      logic            am;
      logic            ok;
      logic [10:0]     bin;
   } vec_t;
   int           checks = 0;
   int           failures = 0;
   logic [6:0]   pat [10];
   vec_t         tbl [9];
   logic [6:0]   q [$];
   logic         pend = 1'b0, pend_am = 1'b0;
   logic         exp_tv = 1'b0, exp_fe = 1'b0, exp_ready = 1'b1;
   logic [10:0]  exp_bin = '0;
   task automatic chk(input string nm, input logic [10:0] act, input logic [10:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%b required=%b t=%0t", nm, act, exp, $time);
      end
   endtask
   function automatic int dec(input logic [6:0] c);
      for (int i = 0; i < 10; i++) if (pat[i] == c) return i;
      return -1;
   endfunction
   function automatic void eval(output logic ok, output logic [10:0] w);
      int v [4];
      int h, m;
      ok = 1'b1;
      for (int i = 0; i < 4; i++) begin
         v[i] = dec(q[i]);
         if (v[i] < 0) begin
            if (!(i == 0 && q[i] == 7'd0)) ok = 1'b0;
            v[i] = 0;
         end
      end
      h = 10 * v[0] + v[1];
      m = 10 * v[2] + v[3];
      if (v[0] > 1 || h > 15 || v[2] > 5) ok = 1'b0;
      w = {~pend_am, h[3:0], m[5:0]};
   endfunction
   task automatic step();
      logic ok;
      logic [10:0] w;
      exp_tv = 1'b0;
      exp_fe = 1'b0;
      if (!rst_n) begin
         q.delete();
         pend = 1'b0;
         exp_bin = '0;
      end else if (pend) begin
         pend = 1'b0;
         eval(ok, w);
         if (ok) begin exp_tv = 1'b1; exp_bin = w; end
         else exp_fe = 1'b1;
         q.delete();
      end else if (bus.seg_valid) begin
         if (q.size() == 0) begin
            if (bus.digit_sel == 2'd0) q.push_back(bus.seg_code);
         end else if (int'(bus.digit_sel) == q.size()) begin
            q.push_back(bus.seg_code);
            if (q.size() == 4) begin pend = 1'b1; pend_am = bus.am_pm_in; end
         end else begin
            exp_fe = 1'b1;
            q.delete();
            if (bus.digit_sel == 2'd0) q.push_back(bus.seg_code);
         end
      end
      exp_ready = !pend;
   endtask
   task automatic tick();
      @(posedge clk);
      step();
      #1;
      chk("cyc_time_valid", 11'(bus.time_valid), 11'(exp_tv));
      chk("cyc_frame_err", 11'(bus.frame_err), 11'(exp_fe));
      chk("cyc_bin_time", bus.bin_time, exp_bin);
      chk("cyc_seg_ready", 11'(bus.seg_ready), 11'(exp_ready));
      @(negedge clk);
   endtask
   task automatic send(input logic [6:0] c, input logic [1:0] s, input logic a);
      logic acc;
      acc = 1'b0;
      bus.seg_code = c;
      bus.digit_sel = s;
      bus.am_pm_in = a;
      bus.seg_valid = 1'b1;
      for (int k = 0; k < 4 && !acc; k++) begin
         acc = bus.seg_ready;
         tick();
      end
      chk("accept", 11'(acc), 11'd1);
      bus.seg_valid = 1'b0;
   endtask
   function automatic vec_t mk(input logic [6:0] a, b, c, d, input logic am, ok, input logic [10:0] bin);
      mk.c = {d, c, b, a};
      mk.am = am;
      mk.ok = ok;
      mk.bin = bin;
   endfunction
   initial begin
      logic [1:0] sel, nxt;
      logic [6:0] code;
      int r;
      pat = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};
      tbl[0] = mk(7'h00,  pat[1], pat[5], pat[1], 1'b1, 1'b1, 11'b0_0001_110011);
      tbl[1] = mk(pat[1], pat[2], pat[5], pat[9], 1'b0, 1'b1, 11'b1_1100_111011);
      tbl[2] = mk(pat[1], pat[6], pat[0], pat[0], 1'b0, 1'b0, 11'b1_1100_111011);
      tbl[3] = mk(pat[1], pat[2], pat[3], 7'h01,  1'b0, 1'b0, 11'b1_1100_111011);
      tbl[4] = mk(pat[0], pat[1], 7'h00,  pat[0], 1'b0, 1'b0, 11'b1_1100_111011);
      tbl[5] = mk(pat[0], pat[9], pat[5], pat[9], 1'b1, 1'b1, 11'b0_1001_111011);
      tbl[6] = mk(pat[1], pat[5], pat[0], pat[0], 1'b0, 1'b1, 11'b1_1111_000000);
      tbl[7] = mk(pat[2], pat[0], pat[0], pat[0], 1'b1, 1'b0, 11'b1_1111_000000);
      tbl[8] = mk(pat[0], pat[0], pat[6], pat[0], 1'b1, 1'b0, 11'b1_1111_000000);
      bus.seg_code = '0;
      bus.digit_sel = '0;
      bus.am_pm_in = 1'b0;
      bus.seg_valid = 1'b0;
      #1 rst_n = 1'b0;
      @(negedge clk);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      for (int i = 0; i < 9; i++) begin
         for (int k = 0; k < 4; k++) send(tbl[i].c[k], 2'(k), tbl[i].am);
         chk("conv_ready_low", 11'(bus.seg_ready), 11'd0);
         tick();
         chk("tbl_time_valid", 11'(bus.time_valid), 11'(tbl[i].ok));
         chk("tbl_frame_err", 11'(bus.frame_err), 11'(!tbl[i].ok));
         chk("tbl_bin_time", bus.bin_time, tbl[i].bin);
         chk("tbl_ready_back", 11'(bus.seg_ready), 11'd1);
      end
      send(pat[0], 2'd0, 1'b1);
      send(pat[1], 2'd1, 1'b1);
      send(pat[0], 2'd0, 1'b1);
      chk("resync_err", 11'(bus.frame_err), 11'd1);
      send(pat[1], 2'd1, 1'b1);
      send(pat[2], 2'd2, 1'b1);
      send(pat[3], 2'd3, 1'b1);
      tick();
      chk("resync_valid", 11'(bus.time_valid), 11'd1);
      chk("resync_bin", bus.bin_time, 11'b0_0001_010111);
      send(pat[0], 2'd0, 1'b0);
      send(pat[2], 2'd2, 1'b0);
      chk("order_err", 11'(bus.frame_err), 11'd1);
      send(pat[1], 2'd1, 1'b0);
      chk("drop_no_err", 11'(bus.frame_err), 11'd0);
      chk("drop_no_valid", 11'(bus.time_valid), 11'd0);
      tick();
      send(pat[1], 2'd0, 1'b0);
      send(pat[2], 2'd1, 1'b0);
      send(pat[3], 2'd2, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("rst_bin", bus.bin_time, 11'd0);
      chk("rst_valid", 11'(bus.time_valid), 11'd0);
      chk("rst_err", 11'(bus.frame_err), 11'd0);
      chk("rst_ready", 11'(bus.seg_ready), 11'd1);
      @(negedge clk);
      tick();
      rst_n = 1'b1;
      send(pat[0], 2'd0, 1'b0);
      send(pat[8], 2'd1, 1'b0);
      send(pat[4], 2'd2, 1'b0);
      send(pat[5], 2'd3, 1'b0);
      tick();
      chk("post_rst_valid", 11'(bus.time_valid), 11'd1);
      chk("post_rst_bin", bus.bin_time, 11'b1_1000_101101);
      nxt = 2'd0;
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 4) == 0) begin
            tick();
            continue;
         end
         sel = $urandom_range(0, 9) < 8 ? nxt : 2'($urandom_range(0, 3));
         r = $urandom_range(0, 19);
         code = r < 16 ? pat[sel == 2'd0 ? $urandom_range(0, 2) : sel == 2'd2 ? $urandom_range(0, 6) : $urandom_range(0, 9)]
              : r < 18 ? 7'd0 : 7'($urandom);
         send(code, sel, 1'($urandom_range(0, 1)));
         nxt = sel + 2'd1;
      end
      repeat (3) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
